ball_engine: RTL

BALL_ENGINE -- requirements
Module: ball_engine

---
 rtl/ball_engine.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ball_engine.sv
// ball_engine: ball motion, wall/paddle/brick bounces, lives and game-over tracking.
// Ports:
//   CLOCK_50    - system clock, all state updates on its rising edge
//   reset       - asynchronous active-high reset
//   row, col    - current scan position from the vga block
//   frame_tick  - one-cycle pulse per frame, after the last visible pixel
//   serve       - one-cycle launch pulse (honoured only in IDLE)
//   paddle_left - left column of the 65-wide paddle on rows 440..459
//   brick_id    - brick code at the current pixel, 0 = no brick
//   ball        - combinational: scan position inside the 8x8 ball (0 in OVER)
//   ball_x/y    - top-left corner of the ball
//   lives       - remaining lives
//   game_over   - high while in OVER
//   hit_valid   - one-cycle pulse when a brick is struck, hit_id holds its code
// Optional feature: define BALL_SPEEDUP_EN to raise the step by one every
// 8 paddle hits, from 2 up to 4.
module ball_engine (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [8:0] row,
    input  logic [9:0] col,
    input  logic       frame_tick,
    input  logic       serve,
    input  logic [9:0] paddle_left,
    input  logic [4:0] brick_id,
    output logic       ball,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic [1:0] lives,
    output logic       game_over,
    output logic       hit_valid,
    output logic [4:0] hit_id
);
    typedef enum logic [1:0] {IDLE, MOVE, LOST, OVER} state_t;
    state_t state_q, state_d;
    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic dxn_q, dxn_d, dyn_q, dyn_d;
    logic [1:0] lives_q, lives_d;
    logic over_q, over_d, hv_q, hv_d, flag_q, flag_d;
    logic [4:0] hid_q, hid_d, bid_q, bid_d, bid_now;
    logic [2:0] speed;
    logic signed [10:0] step, nx, ny;
    logic in_x, in_y, brick_now, flag_now, pad_hit;
`ifdef BALL_SPEEDUP_EN
    logic [2:0] speed_q, speed_d, hits_q, hits_d;
    assign speed = speed_q;
`else
    assign speed = 3'd2;
`endif
    assign in_x = col >= x_q && {1'b0, col} <= {1'b0, x_q} + 11'd7;
    assign in_y = row >= y_q && {1'b0, row} <= {1'b0, y_q} + 10'd7;
    assign ball = in_x && in_y && state_q != OVER;
    // Signed 11-bit next position so steps near the walls never wrap.
    assign step = {8'd0, speed};
    assign nx = $signed({1'b0, x_q}) + (dxn_q ? -step : step);
    assign ny = $signed({2'b0, y_q}) + (dyn_q ? -step : step);
    // Paddle catches a descending ball whose bottom row lands on rows 440..447.
    assign pad_hit = !dyn_q && ny >= 11'sd433 && ny <= 11'sd440 &&
                     {1'b0, x_q} + 11'd7 >= {1'b0, paddle_left} &&
                     {1'b0, x_q} <= {1'b0, paddle_left} + 11'd64;
    // The first brick touched during a frame is the one reported.
    assign brick_now = state_q == MOVE && ball && brick_id != 5'd0;
    assign flag_now = flag_q | brick_now;
    assign bid_now = flag_q ? bid_q : brick_id;
    always_comb begin
        state_d = state_q;
        x_d = x_q;
        y_d = y_q;
        dxn_d = dxn_q;
        dyn_d = dyn_q;
        lives_d = lives_q;
        hid_d = hid_q;
        hv_d = 1'b0;
        flag_d = flag_now;
        bid_d = bid_now;
`ifdef BALL_SPEEDUP_EN
        speed_d = speed_q;
        hits_d = hits_q;
`endif
        if (state_q == IDLE) begin
            if (frame_tick) begin
                x_d = paddle_left + 10'd28;
                y_d = 9'd432;
            end
            if (serve) begin
                state_d = MOVE;
                dxn_d = 1'b0;
                dyn_d = 1'b1;
            end
        end else if (state_q == MOVE && frame_tick) begin
            flag_d = 1'b0;
            x_d = nx <= 11'sd40 ? 10'd40 : nx >= 11'sd582 ? 10'd582 : nx[9:0];
            dxn_d = nx <= 11'sd40 ? 1'b0 : nx >= 11'sd582 ? 1'b1 : dxn_q;
            y_d = ny[8:0];
            // Vertical priority: loss, paddle, brick, top wall.
            if (ny >= 11'sd470) begin
                state_d = LOST;
                lives_d = lives_q - 2'd1;
`ifdef BALL_SPEEDUP_EN
                speed_d = 3'd2;
                hits_d = 3'd0;
`endif
            end else if (pad_hit) begin
                y_d = 9'd432;
                dyn_d = 1'b1;
`ifdef BALL_SPEEDUP_EN
                hits_d = hits_q + 3'd1;
                speed_d = hits_q == 3'd7 && speed_q < 3'd4 ? speed_q + 3'd1 : speed_q;
`endif
            end else if (flag_now) begin
                dyn_d = !dyn_q;
                hv_d = 1'b1;
                hid_d = bid_now;
            end else if (ny <= 11'sd30) begin
                y_d = 9'd30;
                dyn_d = 1'b0;
            end
        end else if (state_q == LOST) begin
            state_d = lives_q == 2'd0 ? OVER : frame_tick ? IDLE : LOST;
        end
        over_d = state_d == OVER;
    end
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q <= 10'd297;
            y_q <= 9'd432;
            dxn_q <= 1'b0;
            dyn_q <= 1'b1;
            lives_q <= 2'd3;
            over_q <= 1'b0;
            hv_q <= 1'b0;
            hid_q <= 5'd0;
            flag_q <= 1'b0;
            bid_q <= 5'd0;
`ifdef BALL_SPEEDUP_EN
            speed_q <= 3'd2;
            hits_q <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            x_q <= x_d;
            y_q <= y_d;
            dxn_q <= dxn_d;
            dyn_q <= dyn_d;
            lives_q <= lives_d;
            over_q <= over_d;
            hv_q <= hv_d;
            hid_q <= hid_d;
            flag_q <= flag_d;
            bid_q <= bid_d;
`ifdef BALL_SPEEDUP_EN
            speed_q <= speed_d;
            hits_q <= hits_d;
`endif
        end
    end
    assign ball_x = x_q;
    assign ball_y = y_q;
    assign lives = lives_q;
    assign game_over = over_q;
    assign hit_valid = hv_q;
    assign hit_id = hid_q;
endmodule
